// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file: default entry type and port-count limits.
package regfile_pkg;

    typedef logic [31:0] reg_entry_t;

    localparam int unsigned MIN_REGS     = 2;
    localparam int unsigned MAX_RD_PORTS = 4;
    localparam int unsigned MAX_WR_PORTS = 4;

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Resolves same-cycle write ports into one write enable and data word per register.
// Highest-index port wins on an address collision; register 0 is never written.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter type         t_entry     = reg_entry_t,
    parameter int unsigned p_num_regs  = 32,
    parameter int unsigned p_num_wr    = 2,
    localparam int unsigned p_addr_bits = $clog2(p_num_regs)
) (
    input  logic [p_addr_bits-1:0] waddr  [p_num_wr],
    input  t_entry                 wdata  [p_num_wr],
    input  logic [p_num_wr-1:0]    wen,
    output logic [p_num_regs-1:0]  reg_we,
    output t_entry                 reg_wd [p_num_regs]
);

    genvar gi, gj;

    generate
        for (gi = 0; gi < p_num_regs; gi++) begin : g_reg
            logic [p_num_wr-1:0] hit;
            t_entry              sel;

            for (gj = 0; gj < p_num_wr; gj++) begin : g_port
                assign hit[gj] = wen[gj] && (waddr[gj] == p_addr_bits'(gi)) && (gi != 0);
            end

            // Ascending scan so the last (highest-index) hitting port overrides.
            always_comb begin
                sel = '0;
                for (int p = 0; p < p_num_wr; p++) begin
                    if (hit[p]) begin
                        sel = wdata[p];
                    end
                end
            end

            assign reg_we[gi] = |hit;
            assign reg_wd[gi] = sel;
        end
    endgenerate

endmodule

// File: rtl/multiport_regfile.sv
// Flop-based multiport register file with a per-register pending (scoreboard) bit.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module multiport_regfile
    import regfile_pkg::*;
#(
    parameter type         t_entry     = reg_entry_t,
    parameter int unsigned p_num_regs  = 32,
    parameter int unsigned p_num_rd    = 2,
    parameter int unsigned p_num_wr    = 2,
    localparam int unsigned p_addr_bits = $clog2(p_num_regs)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [p_addr_bits-1:0] raddr      [p_num_rd],
    output t_entry                 rdata      [p_num_rd],
    output logic [p_num_rd-1:0]    rpend,
    input  logic [p_addr_bits-1:0] waddr      [p_num_wr],
    input  t_entry                 wdata      [p_num_wr],
    input  logic [p_num_wr-1:0]    wen,
    input  logic                   alloc_en,
    input  logic [p_addr_bits-1:0] alloc_addr
);

    genvar gi;

    generate
        if (p_num_regs < MIN_REGS || (p_num_regs & (p_num_regs - 1)) != 0) begin : g_bad_regs
            $error("p_num_regs must be a power of two and at least 2");
        end
        if (p_num_rd < 1 || p_num_rd > MAX_RD_PORTS) begin : g_bad_rd
            $error("p_num_rd out of range");
        end
        if (p_num_wr < 1 || p_num_wr > MAX_WR_PORTS) begin : g_bad_wr
            $error("p_num_wr out of range");
        end
    endgenerate

    t_entry                  regs_q [p_num_regs];
    logic [p_num_regs-1:0]   pend_q;
    logic [p_num_regs-1:0]   reg_we;
    t_entry                  reg_wd [p_num_regs];
    logic [p_num_regs-1:0]   alloc_hit;

    regfile_wr_arbiter #(
        .t_entry    (t_entry),
        .p_num_regs (p_num_regs),
        .p_num_wr   (p_num_wr)
    ) u_wr_arbiter (
        .waddr  (waddr),
        .wdata  (wdata),
        .wen    (wen),
        .reg_we (reg_we),
        .reg_wd (reg_wd)
    );

    generate
        for (gi = 0; gi < p_num_regs; gi++) begin : g_alloc
            assign alloc_hit[gi] = alloc_en && (alloc_addr == p_addr_bits'(gi)) && (gi != 0);
        end
    endgenerate

    // Register 0 is only ever loaded by reset, so it stays zero and never pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < p_num_regs; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int r = 1; r < p_num_regs; r++) begin
                if (reg_we[r]) begin
                    regs_q[r] <= reg_wd[r];
                end
                if (alloc_hit[r]) begin
                    pend_q[r] <= 1'b1;
                end else if (reg_we[r]) begin
                    pend_q[r] <= 1'b0;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < p_num_rd; gi++) begin : g_rd
            t_entry rd_word;
            logic   rd_pend;

            always_comb begin
                rd_word = regs_q[raddr[gi]];
                rd_pend = pend_q[raddr[gi]];
`ifdef REGFILE_BYPASS_EN
                // Forwarding is suppressed during reset so outputs stay zero.
                if (rst && reg_we[raddr[gi]]) begin
                    rd_word = reg_wd[raddr[gi]];
                    rd_pend = alloc_hit[raddr[gi]];
                end
`endif
            end

            assign rdata[gi] = rd_word;
            assign rpend[gi] = rd_pend;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_regfile.sv
// Self-checking bench: directed scenarios on the 32x32b 2R2W build plus randomised
// traffic on 32x32b 2R2W, 8x16b 4R1W and 64x8b 1R4W instances against a reference model.
module tb_multiport_regfile;

    localparam int C_NR [3] = '{32, 8, 64};
    localparam int C_W  [3] = '{32, 16, 8};
    localparam int C_RD [3] = '{2, 4, 1};
    localparam int C_WR [3] = '{2, 1, 4};

    logic        clk;
    logic        rst;
    logic [5:0]  raddr_all [4];
    logic [5:0]  waddr_all [4];
    logic [31:0] wdata_all [4];
    logic [3:0]  wen_all;
    logic        alloc_en;
    logic [5:0]  alloc_addr_all;
    logic [31:0] rdata_s [3][4];
    logic        rpend_s [3][4];

    int tests_run;
    int tests_failed;

    typedef struct {
        int          s;
        int          p;
        logic [31:0] d;
        logic        pd;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] m_regs [3][64];
    logic        m_pend [3][64];

    for (genvar gi = 0; gi < 3; gi++) begin : g_suite
        localparam int unsigned NR = (gi == 0) ? 32 : (gi == 1) ? 8 : 64;
        localparam int unsigned W  = (gi == 0) ? 32 : (gi == 1) ? 16 : 8;
        localparam int unsigned RD = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;
        localparam int unsigned WR = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
        localparam int unsigned AB = $clog2(NR);

        logic [AB-1:0] ra [RD];
        logic [W-1:0]  rd [RD];
        logic [RD-1:0] rp;
        logic [AB-1:0] wa [WR];
        logic [W-1:0]  wd [WR];
        logic [WR-1:0] we;

        for (genvar p = 0; p < RD; p++) begin : g_r
            assign ra[p]          = raddr_all[p][AB-1:0];
            assign rdata_s[gi][p] = 32'(rd[p]);
            assign rpend_s[gi][p] = rp[p];
        end
        for (genvar p = RD; p < 4; p++) begin : g_ru
            assign rdata_s[gi][p] = '0;
            assign rpend_s[gi][p] = 1'b0;
        end
        for (genvar p = 0; p < WR; p++) begin : g_w
            assign wa[p] = waddr_all[p][AB-1:0];
            assign wd[p] = wdata_all[p][W-1:0];
            assign we[p] = wen_all[p];
        end

        multiport_regfile #(
            .t_entry    (logic [W-1:0]),
            .p_num_regs (NR),
            .p_num_rd   (RD),
            .p_num_wr   (WR)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .raddr      (ra),
            .rdata      (rd),
            .rpend      (rp),
            .waddr      (wa),
            .wdata      (wd),
            .wen        (we),
            .alloc_en   (alloc_en),
            .alloc_addr (alloc_addr_all[AB-1:0])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_idle();
        for (int p = 0; p < 4; p++) begin
            raddr_all[p] = '0;
            waddr_all[p] = '0;
            wdata_all[p] = '0;
        end
        wen_all        = '0;
        alloc_en       = 1'b0;
        alloc_addr_all = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 64; r++) begin
                m_regs[s][r] = '0;
                m_pend[s][r] = 1'b0;
            end
        end
    endtask

    // Expected read for suite s, port p, from pre-edge model state and current inputs.
    task automatic model_read(input int s, input int p, output logic [31:0] d, output logic pd);
        int          a;
        logic [31:0] mask;
        a    = int'(raddr_all[p]) % C_NR[s];
        mask = 32'hffff_ffff >> (32 - C_W[s]);
        d    = m_regs[s][a];
        pd   = m_pend[s][a];
`ifdef REGFILE_BYPASS_EN
        if (rst && a != 0) begin
            bit hit;
            hit = 1'b0;
            for (int w = 0; w < C_WR[s]; w++) begin
                if (wen_all[w] && (int'(waddr_all[w]) % C_NR[s]) == a) begin
                    hit = 1'b1;
                    d   = wdata_all[w] & mask;
                end
            end
            if (hit) begin
                pd = alloc_en && ((int'(alloc_addr_all) % C_NR[s]) == a);
            end
        end
`endif
    endtask

    task automatic model_commit();
        int          a;
        logic [31:0] mask;
        if (!rst) begin
            model_clear();
            return;
        end
        for (int s = 0; s < 3; s++) begin
            mask = 32'hffff_ffff >> (32 - C_W[s]);
            for (int w = 0; w < C_WR[s]; w++) begin
                a = int'(waddr_all[w]) % C_NR[s];
                if (wen_all[w] && a != 0) begin
                    m_regs[s][a] = wdata_all[w] & mask;
                    m_pend[s][a] = 1'b0;
                end
            end
            a = int'(alloc_addr_all) % C_NR[s];
            if (alloc_en && a != 0) begin
                m_pend[s][a] = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        drive_idle();
        wen_all[0]   = 1'b1;
        waddr_all[0] = 6'd3;
        wdata_all[0] = 32'hffff;
        alloc_en       = 1'b1;
        alloc_addr_all = 6'd3;
        raddr_all[0] = 6'd3;
        raddr_all[1] = 6'd0;
        next_cycle();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            tests_run++;
            if (rdata_s[0][p] !== 32'h0 || rpend_s[0][p] !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_port%0d: got data %h pend %b, want 0/0", p, rdata_s[0][p], rpend_s[0][p]);
            end
        end
        $display("[TB] reset: write/alloc of r3 held off during reset");
        next_cycle();
        rst = 1'b1;
        drive_idle();
        raddr_all[0] = 6'd3;
        @(negedge clk);
        tests_run++;
        if (rdata_s[0][0] !== 32'h0 || rpend_s[0][0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_dropped_write: got data %h pend %b, want 0/0", rdata_s[0][0], rpend_s[0][0]);
        end
        $display("[TB] reset: r3 after release reads %h", rdata_s[0][0]);
        next_cycle();
    endtask

    task automatic test_basic();
        drive_idle();
        wen_all[0]   = 1'b1;
        waddr_all[0] = 6'd1;
        wdata_all[0] = 32'habcd;
        next_cycle();
        drive_idle();
        raddr_all[0] = 6'd1;
        raddr_all[1] = 6'd1;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            tests_run++;
            if (rdata_s[0][p] !== 32'habcd || rpend_s[0][p] !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_port%0d: got data %h pend %b, want abcd/0", p, rdata_s[0][p], rpend_s[0][p]);
            end
        end
        $display("[TB] basic: r1 reads %h / %h", rdata_s[0][0], rdata_s[0][1]);
        next_cycle();
    endtask

    task automatic test_conflict();
        drive_idle();
        wen_all      = 4'b0011;
        waddr_all[0] = 6'd5;
        wdata_all[0] = 32'h1111;
        waddr_all[1] = 6'd5;
        wdata_all[1] = 32'h2222;
        next_cycle();
        drive_idle();
        raddr_all[0] = 6'd5;
        @(negedge clk);
        tests_run++;
        if (rdata_s[0][0] !== 32'h2222) begin
            tests_failed++;
            $display("FAIL conflict: got %h, want 2222", rdata_s[0][0]);
        end
        $display("[TB] conflict: r5 reads %h", rdata_s[0][0]);
        next_cycle();
    endtask

    task automatic test_scoreboard();
        drive_idle();
        alloc_en       = 1'b1;
        alloc_addr_all = 6'd7;
        next_cycle();
        drive_idle();
        raddr_all[0] = 6'd7;
        @(negedge clk);
        tests_run++;
        if (rpend_s[0][0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL sb_alloc_pend: got %b, want 1", rpend_s[0][0]);
        end
        $display("[TB] scoreboard: alloc r7 pend=%b", rpend_s[0][0]);
        next_cycle();
        drive_idle();
        wen_all[1]   = 1'b1;
        waddr_all[1] = 6'd7;
        wdata_all[1] = 32'h5678;
        next_cycle();
        drive_idle();
        raddr_all[1] = 6'd7;
        @(negedge clk);
        tests_run++;
        if (rpend_s[0][1] !== 1'b0 || rdata_s[0][1] !== 32'h5678) begin
            tests_failed++;
            $display("FAIL sb_write_clear: got data %h pend %b, want 5678/0", rdata_s[0][1], rpend_s[0][1]);
        end
        $display("[TB] scoreboard: write r7 data=%h pend=%b", rdata_s[0][1], rpend_s[0][1]);
        next_cycle();
        drive_idle();
        wen_all[0]     = 1'b1;
        waddr_all[0]   = 6'd9;
        wdata_all[0]   = 32'h9999;
        alloc_en       = 1'b1;
        alloc_addr_all = 6'd9;
        next_cycle();
        drive_idle();
        raddr_all[0] = 6'd9;
        @(negedge clk);
        tests_run++;
        if (rpend_s[0][0] !== 1'b1 || rdata_s[0][0] !== 32'h9999) begin
            tests_failed++;
            $display("FAIL sb_alloc_and_write: got data %h pend %b, want 9999/1", rdata_s[0][0], rpend_s[0][0]);
        end
        $display("[TB] scoreboard: alloc+write r9 data=%h pend=%b", rdata_s[0][0], rpend_s[0][0]);
        next_cycle();
    endtask

    task automatic test_reg_zero();
        drive_idle();
        wen_all[0]     = 1'b1;
        waddr_all[0]   = 6'd0;
        wdata_all[0]   = 32'hbaad;
        alloc_en       = 1'b1;
        alloc_addr_all = 6'd0;
        @(negedge clk);
        tests_run++;
        if (rdata_s[0][0] !== 32'h0 || rpend_s[0][0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_same_cycle: got data %h pend %b, want 0/0", rdata_s[0][0], rpend_s[0][0]);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            tests_run++;
            if (rdata_s[0][p] !== 32'h0 || rpend_s[0][p] !== 1'b0) begin
                tests_failed++;
                $display("FAIL zero_port%0d: got data %h pend %b, want 0/0", p, rdata_s[0][p], rpend_s[0][p]);
            end
        end
        $display("[TB] reg zero: r0 reads %h pend=%b", rdata_s[0][0], rpend_s[0][0]);
        next_cycle();
    endtask

    task automatic test_async_reset();
        drive_idle();
        wen_all[0]   = 1'b1;
        waddr_all[0] = 6'd5;
        wdata_all[0] = 32'hf00d;
        next_cycle();
        drive_idle();
        raddr_all[0] = 6'd5;
        raddr_all[1] = 6'd9;
        @(negedge clk);
        tests_run++;
        if (rdata_s[0][0] !== 32'hf00d || rpend_s[0][1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: got data %h pend9 %b, want f00d/1", rdata_s[0][0], rpend_s[0][1]);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (rdata_s[0][0] !== 32'h0) begin
            tests_failed++;
            $display("FAIL areset_data: got %h, want 0 before next edge", rdata_s[0][0]);
        end
        tests_run++;
        if (rpend_s[0][0] !== 1'b0 || rpend_s[0][1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_pend: got %b%b, want 00", rpend_s[0][1], rpend_s[0][0]);
        end
        $display("[TB] async reset: r5 reads %h mid-cycle", rdata_s[0][0]);
        wen_all[0]   = 1'b1;
        waddr_all[0] = 6'd6;
        wdata_all[0] = 32'h1234;
        @(posedge clk);
        #3;
        rst = 1'b1;
        next_cycle();
        drive_idle();
        raddr_all[0] = 6'd6;
        raddr_all[1] = 6'd5;
        @(negedge clk);
        tests_run++;
        if (rdata_s[0][0] !== 32'h1234 || rdata_s[0][1] !== 32'h0) begin
            tests_failed++;
            $display("FAIL areset_release: got r6 %h r5 %h, want 1234/0", rdata_s[0][0], rdata_s[0][1]);
        end
        $display("[TB] async reset release: r6 reads %h", rdata_s[0][0]);
        next_cycle();
    endtask

    task automatic test_random();
        exp_t e;
        int   errs;
        drive_idle();
        rst = 1'b0;
        model_clear();
        next_cycle();
        rst = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            for (int p = 0; p < 4; p++) begin
                waddr_all[p] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 7)) : 6'($urandom_range(0, 63));
                wdata_all[p] = $urandom;
                raddr_all[p] = ($urandom_range(0, 2) == 0) ? waddr_all[$urandom_range(0, 3)]
                                                           : 6'($urandom_range(0, 63));
            end
            wen_all        = 4'($urandom_range(0, 15));
            alloc_en       = ($urandom_range(0, 2) == 0);
            alloc_addr_all = ($urandom_range(0, 1) == 0) ? raddr_all[0] : 6'($urandom_range(0, 63));
            for (int s = 0; s < 3; s++) begin
                for (int p = 0; p < C_RD[s]; p++) begin
                    e.s = s;
                    e.p = p;
                    model_read(s, p, e.d, e.pd);
                    sb_q.push_back(e);
                end
            end
            @(negedge clk);
            errs = 0;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests_run++;
                if (rdata_s[e.s][e.p] !== e.d || rpend_s[e.s][e.p] !== e.pd) begin
                    tests_failed++;
                    errs++;
                    $display("FAIL rnd_cyc%0d_suite%0d_port%0d: got data %h pend %b, want %h/%b",
                             cyc, e.s, e.p, rdata_s[e.s][e.p], rpend_s[e.s][e.p], e.d, e.pd);
                end
            end
            $display("[TB] random cycle %0d: wen=%b alloc=%b mismatches=%0d", cyc, wen_all, alloc_en, errs);
            model_commit();
            next_cycle();
        end
        drive_idle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        drive_idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_conflict();
        test_scoreboard();
        test_reg_zero();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameter t_entry SHALL default to logic [31:0]; it is the register entry type.
REQ-002 Parameter p_num_regs SHALL default to 32; it is the number of registers and SHALL be a power of two, at least 2.
REQ-003 Parameter p_num_rd SHALL default to 2; it is the number of read ports, range 1..4.
REQ-004 Parameter p_num_wr SHALL default to 2; it is the number of write ports, range 1..4.
REQ-005 Local constant p_addr_bits SHALL equal $clog2(p_num_regs).
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous active-low reset.
REQ-008 raddr  input  [p_num_rd] x p_addr_bits  read addresses.
REQ-009 rdata  output  [p_num_rd] x t_entry  read data.
REQ-010 rpend  output  [p_num_rd] x 1  read register has a pending producer.
REQ-011 waddr  input  [p_num_wr] x p_addr_bits  write addresses.
REQ-012 wdata  input  [p_num_wr] x t_entry  write data.
REQ-013 wen  input  [p_num_wr] x 1  write enables.
REQ-014 alloc_en  input  1  marks alloc_addr pending (new producer issued).
REQ-015 alloc_addr  input  p_addr_bits  register to mark pending.

Function
REQ-016 Register 0 SHALL always read 0 and never be pending; writes and allocs to address 0 SHALL be ignored.
REQ-017 Reads SHALL be combinational with zero latency and return the state held before the next rising edge, unless bypass is enabled (REQ-027).
REQ-018 On each rising edge, every port with wen=1 and a nonzero address SHALL write wdata to regs[waddr].
REQ-019 When two or more enabled write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-020 Each pending bit SHALL be set on the edge where alloc_en=1 and alloc_addr matches it, and SHALL be cleared on the edge where any enabled write targets it.
REQ-021 When alloc and a write target the same address in the same cycle, the data SHALL be written and the pending bit SHALL end set (alloc wins).
REQ-022 rpend[i] SHALL equal pend[raddr[i]] using the pre-edge state.
REQ-023 Address arithmetic SHALL use no wrap beyond p_addr_bits; out-of-range addresses are impossible by construction.

Reset
REQ-024 While rst=0, every register SHALL be 0 and every pending bit SHALL be 0, asynchronously and regardless of clk.
REQ-025 During and after reset, rdata SHALL be 0 and rpend SHALL be 0 for every port; writes and allocs presented while rst=0 SHALL be dropped.
REQ-026 Deassertion of reset mid-operation SHALL take effect cleanly; the first write is captured on the first rising edge with rst=1.

Configuration
REQ-027 With REGFILE_BYPASS_EN defined, rdata[i] SHALL forward the winning same-cycle wdata when an enabled write targets a nonzero raddr[i], and rpend[i] SHALL then read 0 unless alloc also targets that address in the same cycle.
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return stored state only, and a same-cycle write SHALL be visible from the next cycle.

Structure
REQ-029 A shared package regfile_pkg SHALL hold the default entry type and the port-count limits.
REQ-030 One sub-module, regfile_wr_arbiter, SHALL resolve per-address write priority and produce the per-register write enable and data.
REQ-031 Storage SHALL be flops; no memory macros.

Verification
REQ-032 The bench SHALL cover a basic write/read: write 1<-0xabcd on port 0; the next cycle both read ports at address 1 -> 0xabcd, rpend=0.
REQ-033 The bench SHALL cover a write conflict: port0 writes 5<-0x1111 and port1 writes 5<-0x2222 in the same cycle; the next read of 5 -> 0x2222.
REQ-034 The bench SHALL cover the scoreboard: alloc 7; next cycle rpend(7)=1; write 7<-0x5678; next cycle rpend(7)=0, rdata=0x5678; simultaneous alloc and write of 9 -> data stored, rpend(9)=1.
REQ-035 The bench SHALL cover async reset: write 5<-0xf00d, then drive rst=0 mid-cycle; rdata(5) becomes 0 before the next edge, and rpend is all 0.
REQ-036 The bench SHALL cover register zero: write 0<-0xbaad and alloc 0; read of 0 -> 0 and rpend=0.
REQ-037 The bench SHALL cover randomised traffic: 200 cycles against a reference model for each suite (32x32b 2R2W, 8x16b 4R1W, 64x8b 1R4W), run both with and without REGFILE_BYPASS_EN.
